// File: rtl/ram_arb.sv
// ram_arb: two-master arbiter and byte-lane controller for a 16 KiB,
// four-lane data RAM (word index = addr[13:2]) with one write port and one
// synchronous read port (data valid the cycle after ram_r_en).
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   mN_req/we/size/addr/wdata   master N request (N = 0 core LSU, 1 debug)
//   mN_gnt, mN_err           accepted this cycle; accepted but misaligned
//   mN_rvalid, mN_rdata      load data, right-aligned, zero-extended
//   ram_wen/w_addr/w_data    RAM write port (lane enables, replicated data)
//   ram_r_en/r_addr/r_data   RAM read port
//
// Arbitration: a lone requester always wins.  A load and a store to
// different words are co-granted on the two ports.  Otherwise the master
// that did not win the previous conflict (last) is granted.
module ram_arb #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [1:0]    m0_size,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [1:0]    m1_size,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m0_gnt,
    output logic          m0_err,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    output logic          m1_gnt,
    output logic          m1_err,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic [3:0]    ram_wen,
    output logic [AW-1:0] ram_w_addr,
    output logic [31:0]   ram_w_data,
    output logic          ram_r_en,
    output logic [AW-1:0] ram_r_addr,
    input  logic [31:0]   ram_r_data
);

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic m;
        m = 1'b0;
        if (size == 2'd1)
            m = off[0];
        else if (size[1])
            m = (off != 2'b00);
        return m;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            2'd0:    m = 4'b0001;
            2'd1:    m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        case (size)
            2'd0:    r = {4{d[7:0]}};
            2'd1:    r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // last = 1 means master 1 won the most recent conflict, so master 0 is next.
    logic       last, last_nxt;
    logic       rd_pend, rd_owner;
    logic [1:0] rd_off, rd_size;

    logic mis0, mis1, co_grant, contend;
    logic wr0, wr1, rd0, rd1;
    logic [31:0] rd_shifted, rd_formed;

    always_comb begin
        mis0     = misaligned(m0_size, m0_addr[1:0]);
        mis1     = misaligned(m1_size, m1_addr[1:0]);
        contend  = m0_req & m1_req;
        co_grant = contend & (m0_we ^ m1_we) & (m0_addr[13:2] != m1_addr[13:2]);

        // rst gates grants so that nothing is accepted while reset is held.
        m0_gnt = rst & m0_req & (~m1_req | co_grant | last);
        m1_gnt = rst & m1_req & (~m0_req | co_grant | ~last);
        m0_err = m0_gnt & mis0;
        m1_err = m1_gnt & mis1;

        wr0 = m0_gnt & m0_we & ~mis0;
        wr1 = m1_gnt & m1_we & ~mis1;
        rd0 = m0_gnt & ~m0_we & ~mis0;
        rd1 = m1_gnt & ~m1_we & ~mis1;

        last_nxt = last;
        if (contend & ~co_grant & rst)
            last_nxt = m1_gnt;

        ram_wen    = 4'b0000;
        ram_w_addr = '0;
        ram_w_data = 32'h0;
        if (wr0) begin
            ram_wen    = lane_mask(m0_size) << m0_addr[1:0];
            ram_w_addr = m0_addr;
            ram_w_data = replicate(m0_size, m0_wdata);
        end else if (wr1) begin
            ram_wen    = lane_mask(m1_size) << m1_addr[1:0];
            ram_w_addr = m1_addr;
            ram_w_data = replicate(m1_size, m1_wdata);
        end

        ram_r_en   = rd0 | rd1;
        ram_r_addr = '0;
        if (rd0)
            ram_r_addr = m0_addr;
        else if (rd1)
            ram_r_addr = m1_addr;

        rd_shifted = ram_r_data >> {rd_off, 3'b000};
        case (rd_size)
            2'd0:    rd_formed = {24'h0, rd_shifted[7:0]};
            2'd1:    rd_formed = {16'h0, rd_shifted[15:0]};
            default: rd_formed = rd_shifted;
        endcase

        m0_rvalid = rd_pend & ~rd_owner;
        m1_rvalid = rd_pend & rd_owner;
        m0_rdata  = m0_rvalid ? rd_formed : 32'h0;
        m1_rdata  = m1_rvalid ? rd_formed : 32'h0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last     <= 1'b1;
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
            rd_off   <= 2'b00;
            rd_size  <= 2'b00;
        end else begin
            last    <= last_nxt;
            rd_pend <= rd0 | rd1;
            if (rd0) begin
                rd_owner <= 1'b0;
                rd_off   <= m0_addr[1:0];
                rd_size  <= m0_size;
            end else if (rd1) begin
                rd_owner <= 1'b1;
                rd_off   <= m1_addr[1:0];
                rd_size  <= m1_size;
            end
        end
    end

endmodule

// File: tb/tb_ram_arb.sv
module tb_ram_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [1:0]  m0_size = 0, m1_size = 0;
    logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;
    logic        m0_gnt, m0_err, m0_rvalid, m1_gnt, m1_err, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [3:0]  ram_wen;
    logic [31:0] ram_w_addr, ram_w_data, ram_r_addr;
    logic        ram_r_en;
    logic [31:0] ram_r_data;

    always #5 clk = ~clk;

    ram_arb #(.AW(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m0_err(m0_err), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_gnt(m1_gnt), .m1_err(m1_err), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_wen(ram_wen), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
        .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
    );

    // Physical RAM the arbiter drives: byte-lane writes, registered read.
    logic [31:0] ram [0:4095];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_wen[i]) ram[ram_w_addr[13:2]][8*i +: 8] <= ram_w_data[8*i +: 8];
        if (ram_r_en) ram_r_data <= ram[ram_r_addr[13:2]];
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Reference model: byte-addressed memory plus round-robin bookkeeping.
    logic [7:0] ref_mem [0:16383];
    bit         mlast = 1'b1;
    bit         sb_drop = 1'b0;

    typedef struct { int due; logic [31:0] data; } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_mis(input logic [1:0] s, input logic [31:0] a);
        return (nbytes(s) == 2 && a[0]) || (nbytes(s) == 4 && a[1:0] != 0);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [1:0] s);
        logic [31:0] v = 0;
        for (int i = 0; i < nbytes(s); i++) v[8*i +: 8] = ref_mem[a[13:0] + 14'(i)];
        return v;
    endfunction

    // Captured DUT outputs from the last step, for directed checks.
    logic       cap_g0, cap_g1, cap_e0, cap_r_en;
    logic [3:0] cap_wen;
    logic [31:0] cap_wdata;

    // Drive one cycle of requests, check combinational response at the
    // falling edge against the model, update the model, return model grants.
    task automatic step(input bit r0, input bit w0, input logic [1:0] s0, input logic [31:0] a0, input logic [31:0] d0,
                        input bit r1, input bit w1, input logic [1:0] s1, input logic [31:0] a1, input logic [31:0] d1,
                        output bit g0, output bit g1);
        bit co, ok0, ok1;
        logic [3:0] ewen;
        logic [31:0] ewd;
        m0_req = r0; m0_we = w0; m0_size = s0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_size = s1; m1_addr = a1; m1_wdata = d1;
        @(negedge clk);
        co = r0 && r1 && (w0 != w1) && (a0[13:2] != a1[13:2]);
        if (r0 && r1 && !co) begin
            g0 = !mlast;
            g0 = (mlast == 1'b1);
            g1 = !g0;
            mlast = g1;
        end else begin
            g0 = r0;
            g1 = r1;
        end
        ok0 = g0 && !is_mis(s0, a0);
        ok1 = g1 && !is_mis(s1, a1);
        ewen = 0; ewd = 0;
        if (ok0 && w0) begin
            for (int i = 0; i < nbytes(s0); i++) begin
                ewen[a0[1:0] + 2'(i)] = 1'b1;
                ref_mem[a0[13:0] + 14'(i)] = d0[8*i +: 8];
            end
            for (int i = 0; i < 4; i++) ewd[8*i +: 8] = d0[8*(i % nbytes(s0)) +: 8];
        end
        if (ok1 && w1) begin
            for (int i = 0; i < nbytes(s1); i++) begin
                ewen[a1[1:0] + 2'(i)] = 1'b1;
                ref_mem[a1[13:0] + 14'(i)] = d1[8*i +: 8];
            end
            for (int i = 0; i < 4; i++) ewd[8*i +: 8] = d1[8*(i % nbytes(s1)) +: 8];
        end
        chk("m0_gnt", {31'h0, m0_gnt}, {31'h0, g0});
        chk("m1_gnt", {31'h0, m1_gnt}, {31'h0, g1});
        chk("m0_err", {31'h0, m0_err}, {31'h0, g0 && is_mis(s0, a0)});
        chk("m1_err", {31'h0, m1_err}, {31'h0, g1 && is_mis(s1, a1)});
        chk("ram_wen", {28'h0, ram_wen}, {28'h0, ewen});
        chk("ram_r_en", {31'h0, ram_r_en}, {31'h0, (ok0 && !w0) || (ok1 && !w1)});
        if (ewen != 0) chk("ram_w_data", ram_w_data, ewd);
        if (!sb_drop) begin
            if (ok0 && !w0) q0.push_back('{cyc + 1, ref_read(a0, s0)});
            if (ok1 && !w1) q1.push_back('{cyc + 1, ref_read(a1, s1)});
        end
        cap_g0 = m0_gnt; cap_g1 = m1_gnt; cap_e0 = m0_err; cap_r_en = ram_r_en;
        cap_wen = ram_wen; cap_wdata = ram_w_data;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rvalid must match the head of that master's queue,
    // due exactly on this cycle; an expected entry left unserved is a miss.
    always @(negedge clk) begin
        exp_t e;
        if (m0_rvalid) begin
            if (q0.size() == 0 || q0[0].due != cyc) chk("m0_rvalid_unexpected", 1, 0);
            else begin e = q0.pop_front(); chk("m0_rdata", m0_rdata, e.data); end
        end else begin
            chk("m0_rdata_idle", m0_rdata, 0);
            if (q0.size() != 0 && q0[0].due <= cyc) begin
                void'(q0.pop_front()); chk("m0_rvalid_missing", 0, 1);
            end
        end
        if (m1_rvalid) begin
            if (q1.size() == 0 || q1[0].due != cyc) chk("m1_rvalid_unexpected", 1, 0);
            else begin e = q1.pop_front(); chk("m1_rdata", m1_rdata, e.data); end
        end else begin
            chk("m1_rdata_idle", m1_rdata, 0);
            if (q1.size() != 0 && q1[0].due <= cyc) begin
                void'(q1.pop_front()); chk("m1_rvalid_missing", 0, 1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit g0, g1;
        bit p0, pw0, p1, pw1;
        logic [1:0] ps0, ps1;
        logic [31:0] pa0, pd0, pa1, pd1;

        for (int i = 0; i < 4096; i++) ram[i] = 0;
        for (int i = 0; i < 16384; i++) ref_mem[i] = 0;
        ram_r_data = 0;

        // Held in reset with both masters requesting: nothing may be granted.
        m0_req = 1; m1_req = 1; m0_addr = 32'h100; m1_addr = 32'h104;
        repeat (2) @(negedge clk);
        chk("rst_m0_gnt", {31'h0, m0_gnt}, 0);
        chk("rst_m1_gnt", {31'h0, m1_gnt}, 0);
        chk("rst_ram_r_en", {31'h0, ram_r_en}, 0);
        chk("rst_ram_wen", {28'h0, ram_wen}, 0);
        chk("rst_ram_r_addr", ram_r_addr, 0);
        m0_req = 0; m1_req = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;

        // Word store then load from m0.
        step(1, 1, 2, 32'h100, 32'h11223344, 0, 0, 0, 0, 0, g0, g1);
        chk("st_word_wen", {28'h0, cap_wen}, 32'hF);
        step(1, 0, 2, 32'h100, 0, 0, 0, 0, 0, 0, g0, g1);
        // m1 byte store into lane 3, then half load of the upper half.
        step(0, 0, 0, 0, 0, 1, 1, 0, 32'h103, 32'h000000AB, g0, g1);
        chk("st_byte_wen", {28'h0, cap_wen}, 32'h8);
        chk("st_byte_wdata", cap_wdata, 32'hABABABAB);
        step(0, 0, 0, 0, 0, 1, 0, 1, 32'h102, 0, g0, g1);
        chk("ld_half_model", ref_read(32'h102, 2'd1), 32'h0000AB22);

        // Both loading continuously: grants must alternate m0, m1, m0, m1.
        p1 = 1;
        for (int i = 0; i < 4; i++) begin
            step(!g0 || i == 0 ? 1'b1 : 1'b1, 0, 2, 32'h100 + 32'(4 * i), 0, p1, 0, 2, 32'h104, 0, g0, g1);
            chk("alt_m0_gnt", {31'h0, cap_g0}, {31'h0, (i % 2) == 0});
            chk("alt_m1_gnt", {31'h0, cap_g1}, {31'h0, (i % 2) == 1});
        end

        // Load and store to different words: co-granted.
        step(1, 0, 2, 32'h200, 0, 1, 1, 2, 32'h300, 32'hCAFEF00D, g0, g1);
        chk("co_m0", {31'h0, cap_g0}, 1);
        chk("co_m1", {31'h0, cap_g1}, 1);
        // Same word: serialized, m0 first, m1 holds and wins next cycle.
        step(1, 0, 2, 32'h200, 0, 1, 1, 1, 32'h202, 32'h00005A5A, g0, g1);
        chk("same_word_m0", {31'h0, cap_g0}, 1);
        chk("same_word_m1", {31'h0, cap_g1}, 0);
        step(0, 0, 0, 0, 0, 1, 1, 1, 32'h202, 32'h00005A5A, g0, g1);
        chk("same_word_m1_next", {31'h0, cap_g1}, 1);

        // Misaligned word load, then aligned half load.
        step(1, 0, 2, 32'h101, 0, 0, 0, 0, 0, 0, g0, g1);
        chk("mis_err", {31'h0, cap_e0}, 1);
        chk("mis_r_en", {31'h0, cap_r_en}, 0);
        step(1, 0, 1, 32'h102, 0, 0, 0, 0, 0, 0, g0, g1);
        chk("half_no_err", {31'h0, cap_e0}, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // Reset while a load is outstanding drops it.
        sb_drop = 1;
        step(1, 0, 2, 32'h100, 0, 0, 0, 0, 0, 0, g0, g1);
        sb_drop = 0;
        m0_req = 0;
        rst = 0;
        mlast = 1;
        #1;
        chk("rst_drop_rvalid", {31'h0, m0_rvalid}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_rvalid", {31'h0, m0_rvalid}, 0);
        end
        @(posedge clk); #1;
        step(1, 0, 2, 32'h100, 0, 1, 0, 2, 32'h104, 0, g0, g1);
        chk("post_rst_first_m0", {31'h0, cap_g0}, 1);
        step(0, 0, 0, 0, 0, 1, 0, 2, 32'h104, 0, g0, g1);

        // Randomized traffic; ungranted requests are held unchanged.
        p0 = 0; p1 = 0;
        pw0 = 0; pw1 = 0; ps0 = 0; ps1 = 0; pa0 = 0; pa1 = 0; pd0 = 0; pd1 = 0;
        for (int n = 0; n < 600; n++) begin
            if (!p0 && $urandom_range(9) < 7) begin
                p0 = 1; pw0 = $urandom_range(1); ps0 = 2'($urandom_range(3));
                pa0 = 32'h100 + 32'(4 * $urandom_range(5)) + 32'($urandom_range(3));
                if ($urandom_range(3) != 0)
                    pa0 = pa0 & ~32'((nbytes(ps0) - 1));
                pd0 = $urandom;
            end
            if (!p1 && $urandom_range(9) < 7) begin
                p1 = 1; pw1 = $urandom_range(1); ps1 = 2'($urandom_range(3));
                pa1 = 32'h100 + 32'(4 * $urandom_range(5)) + 32'($urandom_range(3));
                if ($urandom_range(3) != 0)
                    pa1 = pa1 & ~32'((nbytes(ps1) - 1));
                pd1 = $urandom;
            end
            step(p0, pw0, ps0, pa0, pd0, p1, pw1, ps1, pa1, pd1, g0, g1);
            if (g0) p0 = 0;
            if (g1) p1 = 0;
        end

        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_arb.md
# ram_arb

Two-master arbiter and byte-lane controller in front of the 16 KiB four-lane data RAM (12-bit word index from address bits [13:2]). It shares the RAM's one write port and one read port between master 0 (core load/store unit) and master 1 (debug/program loader). It also converts byte/half/word requests into lane enables, replicated write data and right-aligned read data. The RAM read port is synchronous: data appears the cycle after `ram_r_en`.

## Interface
- `AW`, default 32: address width of master and RAM address ports.
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `m0_req`, `m1_req`  in  1  request valid; held until granted
- `m0_we`, `m1_we`  in  1  1 = store, 0 = load
- `m0_size`, `m1_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
- `m0_addr`, `m1_addr`  in  AW  byte address
- `m0_wdata`, `m1_wdata`  in  32  store data, right-aligned
- `m0_gnt`, `m1_gnt`  out  1  request accepted this cycle (combinational)
- `m0_err`, `m1_err`  out  1  misaligned request accepted and dropped (same cycle as gnt)
- `m0_rvalid`, `m1_rvalid`  out  1  load data valid
- `m0_rdata`, `m1_rdata`  out  32  load data, right-aligned, zero-extended
- `ram_wen`  out  4  byte-lane write enables
- `ram_w_addr`  out  AW  write byte address
- `ram_w_data`  out  32  lane-replicated write data
- `ram_r_en`  out  1  read enable
- `ram_r_addr`  out  AW  read byte address
- `ram_r_data`  in  32  RAM read data, valid cycle after `ram_r_en`

## Operation
- Alignment:
  - Half with addr[0]=1, or word with addr[1:0]≠0, is misaligned.
  - A granted misaligned request pulses `err`, drives no RAM enable, and produces no `rvalid`.
- Lane mask:
  - Byte = 4'b0001, half = 4'b0011, word = 4'b1111.
  - `ram_wen` = mask << addr[1:0].
- Write data replication:
  - Byte = {4{wdata[7:0]}}.
  - Half = {2{wdata[15:0]}}.
  - Word = wdata.
- Read data:
  - rdata = (`ram_r_data` >> 8·offset), masked to size and zero-extended.
  - Offset and size are those registered at grant.
- Arbitration uses a round-robin pointer `last` (reset 1, so m0 wins first contention). Per cycle:
  - One requester: granted.
  - Both requesting, one load and one store, different word addresses (addr[13:2]): both granted (read and write ports used in parallel); `last` unchanged.
  - Both requesting, same kind, or same word address: grant the master ≠ `last`; `last` ← winner.
- Misaligned requests still take part in arbitration and consume their grant slot.
- Ungranted requests see `gnt`=0 and must hold their request unchanged.
- Unused RAM outputs: `ram_wen`=0, `ram_r_en`=0, addresses/data=0.
- Registered read tracking: `rd_owner`, `rd_off[1:0]`, `rd_size[1:0]`, `rd_pend`.

## Timing
- Grant cycle T:
  - `gnt` and the RAM port signals are combinational in T.
  - A write commits at the rising edge ending T.
- Load granted in T:
  - `rvalid` is high only in T+1, to the owner only, with `rdata` formed from `ram_r_data` in T+1.
  - Loads back-to-back from the same master give one `rvalid` per cycle, in order.
- Read-after-write:
  - Store in T, load of the same word in T+1: the load returns the new data.
  - Same-word load and store in the same cycle are never co-granted, so there is no read-during-write hazard.
- Reset (`rst`=0), asynchronous:
  - `last`=1; `rd_pend`=0.
  - All `gnt`, `err`, `rvalid`, `ram_wen`, `ram_r_en` = 0.
  - `rdata`, addresses, `ram_w_data` = 0.
- Reset during an outstanding load drops it; no `rvalid` after release.
- `rvalid` and `rdata` for the non-owner are 0.

## Test plan
- m0 store word 0x11223344 @0x100, then m0 load @0x100 → `ram_wen`=4'b1111 in T; `m0_rvalid` in T+2 with 0x11223344.
- m1 store byte 0xAB @0x103; m1 load half @0x102 → `ram_wen`=4'b1000, `ram_w_data`=0xABABABAB; `m1_rdata`=0x0000AB22, given 0x11223344 prior.
- m0 and m1 both load continuously for 4 cycles → grants alternate m0,m1,m0,m1; each `rvalid` lands one cycle after its grant to the correct master only.
- m0 load @0x200 and m1 store @0x300 together → both granted same cycle; m0 load @0x200 and m1 store @0x202 together → only m0 (last=1) granted, m1 granted next cycle.
- m0 load word @0x101 → `m0_gnt`=`m0_err`=1, `ram_r_en`=0, no `m0_rvalid`; half @0x102 → no err.
- Grant a load, assert `rst`=0 in T+1 before the edge → `m0_rvalid`=0 immediately and after release; first contention after reset goes to m0.
